// File: rtl/rand_word_collector.sv
// Drives the random engine through restart/go cycles and buffers each result into a small FIFO.
// Optional build macro: RAND_COLLECTOR_DISCARD_ZERO_EN (drop all-zero engine words and re-run).
module rand_word_collector #(
    parameter int nbits = 16,
    parameter int depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_val,
    output logic             req_rdy,
    input  logic [7:0]       req_count,
    output logic             eng_rst,
    output logic             eng_go,
    input  logic             eng_done_val,
    input  logic [nbits-1:0] eng_data,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [nbits-1:0] out_data,
    output logic             busy
);

    localparam int AW = (depth > 1) ? $clog2(depth) : 1;
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(depth);

    typedef enum logic [1:0] {IDLE, RESTART, START, WAIT} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       remaining;
    logic [nbits-1:0] mem [depth];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      occ;

    logic full;
    logic accept;
    logic word_ok;
    logic done_ok;
    logic push;
    logic pop;

    assign full    = (occ == DEPTH_W);
    assign accept  = req_val && (state == IDLE);
    assign done_ok = (state == WAIT) && eng_done_val && !full;
`ifdef RAND_COLLECTOR_DISCARD_ZERO_EN
    // An all-zero word means the LFSR locked up; it is re-run instead of counted.
    assign word_ok = (eng_data != '0);
`else
    assign word_ok = 1'b1;
`endif
    assign push    = done_ok && word_ok;
    assign pop     = out_val && out_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && (req_count != 8'd0)) state_nxt = RESTART;
            RESTART: state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT: begin
                if (done_ok) begin
                    if (word_ok && (remaining == 8'd1)) state_nxt = IDLE;
                    else                                state_nxt = RESTART;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_rdy = (state == IDLE);
        eng_rst = (state == RESTART);
        eng_go  = (state == START);
        busy    = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            remaining <= 8'd0;
        end else if (accept) begin
            remaining <= req_count;
        end else if (push) begin
            remaining <= remaining - 8'd1;
        end
    end

    // FIFO control; storage itself is left unreset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= eng_data;
    end

    assign out_val  = (occ != '0);
    assign out_data = mem[rd_ptr];

endmodule

// File: tb/tb_rand_word_collector.sv
// Directed bench for rand_word_collector with a behavioural engine of programmable latency.
module tb_rand_word_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_val;
    logic        req_rdy;
    logic [7:0]  req_count;
    logic        eng_rst;
    logic        eng_go;
    logic        eng_done_val;
    logic [15:0] eng_data;
    logic        out_val;
    logic        out_rdy;
    logic [15:0] out_data;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Engine model controls, written only by the stimulus process.
    logic [15:0] words [8];
    int          lat = 5;
    int          eng_base = 0;

    int eng_cnt = 0;
    int runs = 0;

    int          go_q [$];
    logic [15:0] out_q [$];
    int          outc_q [$];

    rand_word_collector #(.nbits(16), .depth(4)) dut (
        .clk(clk), .rst(rst),
        .req_val(req_val), .req_rdy(req_rdy), .req_count(req_count),
        .eng_rst(eng_rst), .eng_go(eng_go),
        .eng_done_val(eng_done_val), .eng_data(eng_data),
        .out_val(out_val), .out_rdy(out_rdy), .out_data(out_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Engine: done rises L cycles after the go cycle and holds until restart.
    always @(posedge clk) begin
        if (rst || eng_rst) begin
            eng_done_val <= 1'b0;
            eng_cnt      <= 0;
        end else if (eng_go) begin
            if (lat <= 1) begin
                eng_done_val <= 1'b1;
                eng_data     <= words[(runs - eng_base) & 7];
                runs         <= runs + 1;
            end else begin
                eng_cnt <= lat - 1;
            end
        end else if (eng_cnt == 1) begin
            eng_cnt      <= 0;
            eng_done_val <= 1'b1;
            eng_data     <= words[(runs - eng_base) & 7];
            runs         <= runs + 1;
        end else if (eng_cnt > 1) begin
            eng_cnt <= eng_cnt - 1;
        end
    end

    always @(negedge clk) begin
        if (eng_go) go_q.push_back(cyc);
        if (out_val && out_rdy) begin
            out_q.push_back(out_data);
            outc_q.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [7:0] n, output int t);
        req_val   = 1'b1;
        req_count = n;
        t         = cyc;
        tick();
        req_val   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_val = 1'b0;
        req_count = 8'd0;
        out_rdy = 1'b0;
        for (int i = 0; i < 8; i++) words[i] = 16'h0;
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (req_rdy !== 1'b1 || out_val !== 1'b0 || busy !== 1'b0 ||
                eng_rst !== 1'b0 || eng_go !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cyc%0d: rdy=%b val=%b busy=%b erst=%b go=%b, required 1 0 0 0 0",
                         i, req_rdy, out_val, busy, eng_rst, eng_go);
            end
            tick();
        end
    endtask

    task automatic test_three_words();
        int t;
        int g0;
        int o0;
        int first_rdy;
        logic [15:0] exp [3];
        exp[0] = 16'h1234; exp[1] = 16'hBEEF; exp[2] = 16'h0F0F;
        eng_base = runs;
        for (int i = 0; i < 3; i++) words[i] = exp[i];
        lat = 5;
        out_rdy = 1'b1;
        g0 = go_q.size();
        o0 = out_q.size();
        do_req(8'd3, t);
        checks++;
        if (req_rdy !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL accept_busy: rdy=%b busy=%b, required 0 1", req_rdy, busy);
        end
        first_rdy = -1;
        repeat (30) begin
            tick();
            if (first_rdy < 0 && req_rdy === 1'b1) first_rdy = cyc;
        end
        checks++;
        if (first_rdy !== t + 22) begin
            errors++;
            $display("FAIL main_req_rdy: cycle %0d, required %0d", first_rdy, t + 22);
        end
        checks++;
        if (go_q.size() - g0 != 3 || out_q.size() - o0 != 3) begin
            errors++;
            $display("FAIL main_counts: go=%0d out=%0d, required 3 3", go_q.size() - g0, out_q.size() - o0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (go_q[g0 + i] !== t + 2 + 7 * i) begin
                    errors++;
                    $display("FAIL main_go%0d: cycle %0d, required %0d", i, go_q[g0 + i], t + 2 + 7 * i);
                end
                checks++;
                if (out_q[o0 + i] !== exp[i] || outc_q[o0 + i] !== t + 8 + 7 * i) begin
                    errors++;
                    $display("FAIL main_out%0d: %h at %0d, required %h at %0d",
                             i, out_q[o0 + i], outc_q[o0 + i], exp[i], t + 8 + 7 * i);
                end
            end
        end
    endtask

    task automatic test_zero_count();
        int t;
        int g0;
        g0 = go_q.size();
        do_req(8'd0, t);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (req_rdy !== 1'b1 || busy !== 1'b0 || out_val !== 1'b0 || eng_rst !== 1'b0) begin
                errors++;
                $display("FAIL zero_count cyc%0d: rdy=%b busy=%b val=%b erst=%b, required 1 0 0 0",
                         i, req_rdy, busy, out_val, eng_rst);
            end
            tick();
        end
        checks++;
        if (go_q.size() != g0) begin
            errors++;
            $display("FAIL zero_count_go: %0d pulses, required 0", go_q.size() - g0);
        end
    endtask

    task automatic test_backpressure();
        int t;
        int g0;
        int o0;
        eng_base = runs;
        for (int i = 0; i < 6; i++) words[i] = 16'h1111 * 16'(i + 1);
        lat = 3;
        out_rdy = 1'b0;
        g0 = go_q.size();
        o0 = out_q.size();
        do_req(8'd6, t);
        repeat (40) tick();
        checks++;
        if (go_q.size() - g0 != 5 || busy !== 1'b1 || out_val !== 1'b1 || req_rdy !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall: go=%0d busy=%b val=%b rdy=%b, required 5 1 1 0",
                     go_q.size() - g0, busy, out_val, req_rdy);
        end
        repeat (20) tick();
        checks++;
        if (go_q.size() - g0 != 5 || eng_go !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_go: go=%0d, required 5", go_q.size() - g0);
        end
        out_rdy = 1'b1;
        repeat (60) tick();
        checks++;
        if (out_q.size() - o0 != 6 || req_rdy !== 1'b1 || out_val !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: words=%0d rdy=%b val=%b, required 6 1 0", out_q.size() - o0, req_rdy, out_val);
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (out_q[o0 + i] !== 16'h1111 * 16'(i + 1)) begin
                    errors++;
                    $display("FAIL bp_word%0d: %h, required %h", i, out_q[o0 + i], 16'h1111 * 16'(i + 1));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int t;
        int o0;
        eng_base = runs;
        words[0] = 16'hA001; words[1] = 16'hA002; words[2] = 16'hA003; words[3] = 16'hA004;
        lat = 3;
        out_rdy = 1'b0;
        do_req(8'd4, t);
        while (cyc < t + 13) tick();
        checks++;
        if (busy !== 1'b1 || out_val !== 1'b1 || eng_go !== 1'b0 || eng_rst !== 1'b0) begin
            errors++;
            $display("FAIL mid_before: busy=%b val=%b go=%b erst=%b, required 1 1 0 0", busy, out_val, eng_go, eng_rst);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_val !== 1'b0 || busy !== 1'b0 || req_rdy !== 1'b1 || eng_go !== 1'b0 || eng_rst !== 1'b0) begin
            errors++;
            $display("FAIL mid_after: val=%b busy=%b rdy=%b go=%b erst=%b, required 0 0 1 0 0",
                     out_val, busy, req_rdy, eng_go, eng_rst);
        end
        eng_base = runs;
        words[0] = 16'hC0DE;
        out_rdy = 1'b1;
        o0 = out_q.size();
        do_req(8'd1, t);
        repeat (15) tick();
        checks++;
        if (out_q.size() - o0 != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_redo: words=%0d busy=%b, required 1 0", out_q.size() - o0, busy);
        end else begin
            checks++;
            if (out_q[o0] !== 16'hC0DE) begin
                errors++;
                $display("FAIL mid_redo_word: %h, required c0de", out_q[o0]);
            end
        end
    endtask

    task automatic test_zero_word();
        int t;
        int g0;
        int o0;
        logic [15:0] exp_word;
        int exp_go;
`ifdef RAND_COLLECTOR_DISCARD_ZERO_EN
        exp_word = 16'h5A5A;
        exp_go   = 2;
`else
        exp_word = 16'h0000;
        exp_go   = 1;
`endif
        eng_base = runs;
        words[0] = 16'h0000;
        words[1] = 16'h5A5A;
        lat = 3;
        out_rdy = 1'b1;
        g0 = go_q.size();
        o0 = out_q.size();
        do_req(8'd1, t);
        repeat (25) tick();
        checks++;
        if (go_q.size() - g0 != exp_go || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_word_runs: go=%0d busy=%b, required %0d 0", go_q.size() - g0, busy, exp_go);
        end
        checks++;
        if (out_q.size() - o0 != 1) begin
            errors++;
            $display("FAIL zero_word_count: %0d words, required 1", out_q.size() - o0);
        end else if (out_q[o0] !== exp_word) begin
            errors++;
            $display("FAIL zero_word_data: %h, required %h", out_q[o0], exp_word);
        end
    endtask

    initial begin
        test_reset();
        test_three_words();
        test_zero_count();
        test_backpressure();
        test_reset_mid();
        test_zero_word();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
